// File: rtl/ps2_keyboard_matrix.sv
// PS/2 set-2 keyboard receiver feeding an emulated C64 8x8 keyboard matrix.
// The host scans the matrix by driving active-low rows (CIA1 port A) and
// reading active-low columns (CIA1 port B). F12 acts as the RESTORE key.
module ps2_keyboard_matrix #(
   parameter int TIMEOUT_CYCLES = 16384
) (
   input  logic       dot_clk,
   input  logic       res_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic [7:0] keyboard_ROW,
   output logic [7:0] keyboard_COL,
   output logic       restore_n,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   // Lookup result: pos is {row, col} of the C64 matrix, written in octal.
   typedef struct packed {
      logic       hit;
      logic       restore;
      logic [5:0] pos;
   } key_t;

   logic          ps2_clk_meta, ps2_clk_sync, ps2_clk_prev;
   logic          ps2_data_meta, ps2_data_sync;
   logic          ps2_fall;
   state_t        state_reg;
   logic [2:0]    bit_cnt_reg;
   logic [7:0]    shift_reg;
   logic          parity_reg;
   logic [TW-1:0] to_cnt_reg;
   logic          ext_reg, rel_reg;
   logic [7:0][7:0] matrix;
   key_t          key;

   // Map a (extended, code) pair to a C64 matrix position or RESTORE.
   function automatic key_t lookup(input logic ext, input logic [7:0] code);
      key_t k;
      k = '0;
      k.hit = 1'b1;
      if (ext) begin
         case (code)
            8'h74:   k.pos = 6'o02;   // cursor right
            8'h72:   k.pos = 6'o07;   // cursor down
            8'h6C:   k.pos = 6'o63;   // HOME
            8'h7D:   k.pos = 6'o66;   // PgUp -> up-arrow
            8'h71:   k.pos = 6'o00;   // Delete -> DEL
            8'h14:   k.pos = 6'o72;   // right ctrl -> CTRL
            8'h11:   k.pos = 6'o75;   // right alt -> C=
            8'h5A:   k.pos = 6'o01;   // keypad enter -> RETURN
            default: k.hit = 1'b0;
         endcase
      end else begin
         case (code)
            8'h16: k.pos = 6'o70;   8'h1E: k.pos = 6'o73;   // 1 2
            8'h26: k.pos = 6'o10;   8'h25: k.pos = 6'o13;   // 3 4
            8'h2E: k.pos = 6'o20;   8'h36: k.pos = 6'o23;   // 5 6
            8'h3D: k.pos = 6'o30;   8'h3E: k.pos = 6'o33;   // 7 8
            8'h46: k.pos = 6'o40;   8'h45: k.pos = 6'o43;   // 9 0
            8'h15: k.pos = 6'o76;   8'h1D: k.pos = 6'o11;   // Q W
            8'h24: k.pos = 6'o16;   8'h2D: k.pos = 6'o21;   // E R
            8'h2C: k.pos = 6'o26;   8'h35: k.pos = 6'o31;   // T Y
            8'h3C: k.pos = 6'o36;   8'h43: k.pos = 6'o41;   // U I
            8'h44: k.pos = 6'o46;   8'h4D: k.pos = 6'o51;   // O P
            8'h1C: k.pos = 6'o12;   8'h1B: k.pos = 6'o15;   // A S
            8'h23: k.pos = 6'o22;   8'h2B: k.pos = 6'o25;   // D F
            8'h34: k.pos = 6'o32;   8'h33: k.pos = 6'o35;   // G H
            8'h3B: k.pos = 6'o42;   8'h42: k.pos = 6'o45;   // J K
            8'h4B: k.pos = 6'o52;   8'h1A: k.pos = 6'o14;   // L Z
            8'h22: k.pos = 6'o27;   8'h21: k.pos = 6'o24;   // X C
            8'h2A: k.pos = 6'o37;   8'h32: k.pos = 6'o34;   // V B
            8'h31: k.pos = 6'o47;   8'h3A: k.pos = 6'o44;   // N M
            8'h41: k.pos = 6'o57;   8'h49: k.pos = 6'o54;   // , .
            8'h4A: k.pos = 6'o67;   8'h4C: k.pos = 6'o55;   // / ;->:
            8'h52: k.pos = 6'o62;   8'h54: k.pos = 6'o56;   // '->; [->@
            8'h5B: k.pos = 6'o61;   8'h4E: k.pos = 6'o53;   // ]->* -
            8'h55: k.pos = 6'o65;   8'h5D: k.pos = 6'o60;   // = \->pound
            8'h0E: k.pos = 6'o71;   8'h79: k.pos = 6'o50;   // `->left-arrow kp+
            8'h5A: k.pos = 6'o01;   8'h66: k.pos = 6'o00;   // RETURN DEL
            8'h05: k.pos = 6'o04;   8'h04: k.pos = 6'o05;   // F1 F3
            8'h03: k.pos = 6'o06;   8'h83: k.pos = 6'o03;   // F5 F7
            8'h12: k.pos = 6'o17;   8'h59: k.pos = 6'o64;   // LSHIFT RSHIFT
            8'h14: k.pos = 6'o72;   8'h0D: k.pos = 6'o72;   // LCTRL/TAB -> CTRL
            8'h11: k.pos = 6'o75;   8'h76: k.pos = 6'o77;   // LALT->C= ESC->RUN/STOP
            8'h29: k.pos = 6'o74;                           // SPACE
            8'h07: k.restore = 1'b1;                        // F12 -> RESTORE
            default: k.hit = 1'b0;
         endcase
      end
      return k;
   endfunction

   // Two-flop synchronizers plus one extra stage of the clock for edge detection.
   always_ff @(posedge dot_clk or negedge res_n) begin
      if (!res_n) begin
         ps2_clk_meta  <= 1'b1;
         ps2_clk_sync  <= 1'b1;
         ps2_clk_prev  <= 1'b1;
         ps2_data_meta <= 1'b1;
         ps2_data_sync <= 1'b1;
      end else begin
         ps2_clk_meta  <= ps2_clk;
         ps2_clk_sync  <= ps2_clk_meta;
         ps2_clk_prev  <= ps2_clk_sync;
         ps2_data_meta <= ps2_data;
         ps2_data_sync <= ps2_data_meta;
      end
   end

   assign ps2_fall = ps2_clk_prev & ~ps2_clk_sync;

   // Frame receiver: start, 8 data bits LSB first, odd parity, stop; with inactivity timeout.
   always_ff @(posedge dot_clk or negedge res_n) begin
      if (!res_n) begin
         state_reg   <= S_IDLE;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         parity_reg  <= 1'b0;
         to_cnt_reg  <= '0;
         scan_code   <= '0;
         scan_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         scan_valid  <= 1'b0;
         frame_error <= 1'b0;
         if (state_reg == S_IDLE || ps2_fall) begin
            to_cnt_reg <= '0;
         end else if (to_cnt_reg == TO_MAX) begin
            // Device went silent mid-frame: drop the partial byte quietly.
            to_cnt_reg <= '0;
            state_reg  <= S_IDLE;
         end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
         end
         if (ps2_fall) begin
            case (state_reg)
               S_IDLE: begin
                  if (!ps2_data_sync) begin
                     state_reg   <= S_DATA;
                     bit_cnt_reg <= '0;
                  end
               end
               S_DATA: begin
                  shift_reg   <= {ps2_data_sync, shift_reg[7:1]};
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == 3'd7) state_reg <= S_PARITY;
               end
               S_PARITY: begin
                  parity_reg <= ps2_data_sync;
                  state_reg  <= S_STOP;
               end
               S_STOP: begin
                  if (ps2_data_sync && (^{shift_reg, parity_reg})) begin
                     scan_code  <= shift_reg;
                     scan_valid <= 1'b1;
                  end else begin
                     frame_error <= 1'b1;
                  end
                  state_reg <= S_IDLE;
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

   always_comb key = lookup(ext_reg, scan_code);

   // Prefix tracking and matrix/RESTORE update, one clock after each accepted byte.
   always_ff @(posedge dot_clk or negedge res_n) begin
      if (!res_n) begin
         ext_reg   <= 1'b0;
         rel_reg   <= 1'b0;
         matrix    <= '0;
         restore_n <= 1'b1;
      end else if (scan_valid) begin
         if (scan_code == 8'hE0) begin
            ext_reg <= 1'b1;
         end else if (scan_code == 8'hF0) begin
            rel_reg <= 1'b1;
         end else begin
            if (key.hit) begin
               if (key.restore) restore_n <= rel_reg;
               else matrix[key.pos[5:3]][key.pos[2:0]] <= ~rel_reg;
            end
            ext_reg <= 1'b0;
            rel_reg <= 1'b0;
         end
      end
   end

   // Column sense: a column reads low when any pressed key in it sits on a driven row.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_col
         logic [7:0] col_bits;
         for (genvar gr = 0; gr < 8; gr++) begin : g_row
            assign col_bits[gr] = matrix[gr][gi];
         end
         assign keyboard_COL[gi] = ~|(col_bits & ~keyboard_ROW);
      end
   endgenerate

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// Directed bench for ps2_keyboard_matrix: a table of frames with expected
// matrix read-back, plus hand sequences for timeout, row glitches and reset.
module tb_ps2_keyboard_matrix;

   localparam int TO   = 256;
   localparam int HALF = 8;

   logic       dot_clk = 1'b0;
   logic       res_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keyboard_ROW;
   logic [7:0] keyboard_COL;
   logic       restore_n;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       frame_error;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   logic [7:0] last_code = 8'h00;

   ps2_keyboard_matrix #(.TIMEOUT_CYCLES(TO)) dut (
      .dot_clk      (dot_clk),
      .res_n        (res_n),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .keyboard_ROW (keyboard_ROW),
      .keyboard_COL (keyboard_COL),
      .restore_n    (restore_n),
      .scan_code    (scan_code),
      .scan_valid   (scan_valid),
      .frame_error  (frame_error)
   );

   always #5 dot_clk = ~dot_clk;

   // Count strobes away from the active edge.
   always @(negedge dot_clk) begin
      if (scan_valid) begin
         valid_cnt = valid_cnt + 1;
         last_code = scan_code;
      end
      if (frame_error) err_cnt = err_cnt + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad);
      logic p;
      p = bad ? (^code) : ~(^code);
      return {1'b1, p, code, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(posedge dot_clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge dot_clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input logic bad);
      send_bits(mk_frame(code, bad), 11);
      repeat (12) @(posedge dot_clk);
   endtask

   typedef struct {
      logic       send;
      logic [7:0] code;
      logic       bad;
      logic [7:0] row;
      logic [7:0] col;
      logic       rst;
   } vec_t;

   vec_t vec [29];

   initial begin
      int v0, e0;
      vec[0]  = '{1'b1, 8'h1C, 1'b0, 8'hFD, 8'hFB, 1'b1};  // A pressed
      vec[1]  = '{1'b0, 8'h00, 1'b0, 8'hFE, 8'hFF, 1'b1};
      vec[2]  = '{1'b1, 8'hF0, 1'b0, 8'h00, 8'hFB, 1'b1};
      vec[3]  = '{1'b1, 8'h1C, 1'b0, 8'h00, 8'hFF, 1'b1};  // A released
      vec[4]  = '{1'b1, 8'h12, 1'b0, 8'hFF, 8'hFF, 1'b1};  // LSHIFT
      vec[5]  = '{1'b1, 8'h29, 1'b0, 8'h7D, 8'h6F, 1'b1};  // SPACE
      vec[6]  = '{1'b0, 8'h00, 1'b0, 8'hFF, 8'hFF, 1'b1};
      vec[7]  = '{1'b1, 8'h5A, 1'b1, 8'hFE, 8'hFF, 1'b1};  // bad parity
      vec[8]  = '{1'b1, 8'h5A, 1'b0, 8'hFE, 8'hFD, 1'b1};  // RETURN
      vec[9]  = '{1'b1, 8'hF0, 1'b0, 8'hFE, 8'hFD, 1'b1};
      vec[10] = '{1'b1, 8'h5A, 1'b0, 8'hFE, 8'hFF, 1'b1};
      vec[11] = '{1'b1, 8'h07, 1'b0, 8'hFF, 8'hFF, 1'b0};  // RESTORE down
      vec[12] = '{1'b1, 8'hF0, 1'b0, 8'hFF, 8'hFF, 1'b0};
      vec[13] = '{1'b1, 8'h07, 1'b0, 8'hFF, 8'hFF, 1'b1};  // RESTORE up
      vec[14] = '{1'b1, 8'hE0, 1'b0, 8'hFE, 8'hFF, 1'b1};
      vec[15] = '{1'b1, 8'h74, 1'b0, 8'hFE, 8'hFB, 1'b1};  // CRSR right
      vec[16] = '{1'b1, 8'hE0, 1'b0, 8'hFE, 8'hFB, 1'b1};
      vec[17] = '{1'b1, 8'hF0, 1'b0, 8'hFE, 8'hFB, 1'b1};
      vec[18] = '{1'b1, 8'h74, 1'b0, 8'hFE, 8'hFF, 1'b1};
      vec[19] = '{1'b1, 8'hE0, 1'b0, 8'hFE, 8'hFF, 1'b1};
      vec[20] = '{1'b1, 8'h72, 1'b0, 8'hFE, 8'h7F, 1'b1};  // CRSR down
      vec[21] = '{1'b1, 8'h1C, 1'b0, 8'hFD, 8'h7B, 1'b1};
      vec[22] = '{1'b1, 8'h1C, 1'b0, 8'hFD, 8'h7B, 1'b1};  // typematic
      vec[23] = '{1'b1, 8'hF0, 1'b0, 8'hFD, 8'h7B, 1'b1};
      vec[24] = '{1'b1, 8'hAA, 1'b0, 8'hFD, 8'h7B, 1'b1};  // clears rel
      vec[25] = '{1'b1, 8'h1C, 1'b0, 8'hFD, 8'h7B, 1'b1};
      vec[26] = '{1'b1, 8'hF0, 1'b0, 8'hFD, 8'h7B, 1'b1};
      vec[27] = '{1'b1, 8'h1C, 1'b0, 8'hFD, 8'h7F, 1'b1};
      vec[28] = '{1'b1, 8'hE1, 1'b0, 8'h7F, 8'hEF, 1'b1};  // unmapped

      res_n = 1'b0;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      keyboard_ROW = 8'h00;
      repeat (3) @(posedge dot_clk);
      @(negedge dot_clk);
      check("rst_col", keyboard_COL, 8'hFF);
      check("rst_code", scan_code, 8'h00);
      check("rst_valid", scan_valid, 0);
      check("rst_ferr", frame_error, 0);
      check("rst_restore", restore_n, 1);
      res_n = 1'b1;
      repeat (3) @(posedge dot_clk);

      for (int i = 0; i < 29; i++) begin
         v0 = valid_cnt;
         e0 = err_cnt;
         if (vec[i].send) send_frame(vec[i].code, vec[i].bad);
         else repeat (4) @(posedge dot_clk);
         @(negedge dot_clk);
         keyboard_ROW = vec[i].row;
         #1;
         check($sformatf("v%0d_col", i), keyboard_COL, vec[i].col);
         check($sformatf("v%0d_restore", i), restore_n, vec[i].rst);
         check($sformatf("v%0d_nvalid", i), valid_cnt - v0, (vec[i].send && !vec[i].bad) ? 1 : 0);
         check($sformatf("v%0d_nferr", i), err_cnt - e0, (vec[i].send && vec[i].bad) ? 1 : 0);
         if (vec[i].send && !vec[i].bad)
            check($sformatf("v%0d_code", i), last_code, vec[i].code);
      end

      // Row changes are visible combinationally, within one cycle.
      @(negedge dot_clk);
      keyboard_ROW = 8'h7D;
      #1 check("row7D_col", keyboard_COL, 8'h6F);
      @(posedge dot_clk);
      #1 keyboard_ROW = 8'hFF;
      #1 check("rowFF_glitch_col", keyboard_COL, 8'hFF);
      @(posedge dot_clk);
      #1 keyboard_ROW = 8'h7D;
      #1 check("row7D_back_col", keyboard_COL, 8'h6F);

      // Timeout: release SPACE, abandon a partial frame, then SPACE again.
      send_frame(8'hF0, 1'b0);
      send_frame(8'h29, 1'b0);
      @(negedge dot_clk);
      keyboard_ROW = 8'h7F;
      #1 check("space_rel_col", keyboard_COL, 8'hFF);
      v0 = valid_cnt;
      e0 = err_cnt;
      send_bits(mk_frame(8'h1C, 1'b0), 4);
      repeat (TO + 10) @(posedge dot_clk);
      send_frame(8'h29, 1'b0);
      @(negedge dot_clk);
      check("to_nvalid", valid_cnt - v0, 1);
      check("to_nferr", err_cnt - e0, 0);
      check("to_code", last_code, 8'h29);
      check("to_col", keyboard_COL, 8'hEF);

      // Reset mid-frame clears matrix and RESTORE.
      send_frame(8'hE0, 1'b0);
      send_frame(8'h74, 1'b0);
      send_frame(8'h07, 1'b0);
      @(negedge dot_clk);
      keyboard_ROW = 8'hFE;
      #1 check("pre_rst_col", keyboard_COL, 8'h7B);
      check("pre_rst_restore", restore_n, 0);
      send_bits(mk_frame(8'h5A, 1'b0), 3);
      @(negedge dot_clk);
      res_n = 1'b0;
      keyboard_ROW = 8'h00;
      #1 check("in_rst_col", keyboard_COL, 8'hFF);
      check("in_rst_restore", restore_n, 1);
      check("in_rst_code", scan_code, 8'h00);
      repeat (2) @(negedge dot_clk);
      res_n = 1'b1;
      repeat (2) @(negedge dot_clk);
      check("post_rst_col", keyboard_COL, 8'hFF);
      check("post_rst_restore", restore_n, 1);
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(8'h1C, 1'b0);
      @(negedge dot_clk);
      keyboard_ROW = 8'hFD;
      #1 check("post_rst_nvalid", valid_cnt - v0, 1);
      check("post_rst_nferr", err_cnt - e0, 0);
      check("post_rst_code", last_code, 8'h1C);
      check("post_rst_a_col", keyboard_COL, 8'hFB);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
